// File: rtl/instr_prefetch_queue_pkg.sv
// Shared widths, the assembled-instruction record and the halfword pop encoding
// used by the AAP instruction prefetch queue.
package instr_prefetch_queue_pkg;

    localparam int INSTR_ADDR_W = 20;
    localparam int HALF_W       = 16;
    localparam int INSTR_W      = 32;
    localparam int IS32_BIT     = 15;

    typedef logic [INSTR_ADDR_W-1:0] pc_t;
    typedef logic [HALF_W-1:0]       half_t;

    typedef struct packed {
        logic [INSTR_W-1:0] data;
        pc_t                pc;
        logic               is32;
    } instr_t;

    typedef enum logic [1:0] {
        POP_NONE = 2'd0,
        POP_ONE  = 2'd1,
        POP_TWO  = 2'd2
    } pop_e;

    function automatic logic half_is32(input half_t hw);
        return hw[IS32_BIT];
    endfunction

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Memory read, redirect and decoder handshake bundle of the prefetch queue.
// master = prefetch queue side, slave = memory/execute/decoder side.
interface instr_prefetch_queue_if;
    import instr_prefetch_queue_pkg::*;

    logic               mem_rd_en;
    pc_t                mem_rd_addr;
    half_t              mem_rd_data;
    logic               redirect_valid;
    pc_t                redirect_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr_data;
    pc_t                instr_pc;
    logic               instr_is32;

    modport master (
        output mem_rd_en, mem_rd_addr, instr_valid, instr_data, instr_pc, instr_is32,
        input  mem_rd_data, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_rd_en, mem_rd_addr, instr_valid, instr_data, instr_pc, instr_is32,
        output mem_rd_data, redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/instr_prefetch_queue_prefetch_fifo.sv
// Circular halfword buffer: one push per cycle, pops of 0/1/2 halfwords,
// synchronous clear; exposes the head word and the word behind it.
module prefetch_fifo
    import instr_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  half_t                  push_data,
    input  pop_e                   pop,
    input  logic                   clear,
    output half_t                  head_word,
    output half_t                  next_word,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    half_t              buf_mem [DEPTH];
    logic [PTR_W-1:0]   head_ptr;
    logic [PTR_W-1:0]   tail_ptr;
    logic [CNT_W-1:0]   pop_amt;

    assign pop_amt = CNT_W'(pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            head_ptr <= head_ptr + PTR_W'(pop);
            count    <= count + CNT_W'(push) - pop_amt;
        end
    end

    // Storage carries no reset; only the pointers and count define what is live.
    always_ff @(posedge clock) begin
        if (push && !clear) begin
            buf_mem[tail_ptr] <= push_data;
        end
    end

    assign head_word = buf_mem[head_ptr];
    assign next_word = buf_mem[head_ptr + PTR_W'(1)];

    fifo_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        clear || ({1'b0, count} + (CNT_W+1)'(push) <= (CNT_W+1)'(DEPTH) + {1'b0, pop_amt}));

    fifo_no_underflow: assert property (@(posedge clock) disable iff (!reset)
        clear || (pop_amt <= count));

endmodule

// File: rtl/instr_prefetch_queue.sv
// AAP instruction prefetch queue: streams halfwords from instruction memory and
// presents complete 16/32-bit instructions with their PC to the decoder.
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int  DEPTH    = 4,
    parameter pc_t RESET_PC = 20'h00000
) (
    input  logic                  clock,
    input  logic                  reset,
    instr_prefetch_queue_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    pc_t              fetch_pc;
    pc_t              head_pc;
    logic             inflight;
    logic             issue;
    logic [CNT_W-1:0] count;
    half_t            head_word;
    half_t            next_word;
    logic             has_one;
    logic             has_two;
    logic             head_is32;
    logic             head_valid;
    pop_e             pop;
    instr_t           head_instr;

    prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight),
        .push_data (bus.mem_rd_data),
        .pop       (pop),
        .clear     (bus.redirect_valid),
        .head_word (head_word),
        .next_word (next_word),
        .count     (count)
    );

    // Credit counts queued plus in-flight words; same-cycle pops are not credited.
    assign issue = ((count + CNT_W'(inflight)) < CNT_W'(DEPTH)) && !bus.redirect_valid;

    assign has_one    = (count != '0);
    assign has_two    = (count >= CNT_W'(2));
    assign head_is32  = has_one && half_is32(head_word);
    assign head_valid = !bus.redirect_valid && (head_is32 ? has_two : has_one);

    assign pop = !(head_valid && bus.instr_ready) ? POP_NONE :
                 head_is32                        ? POP_TWO  : POP_ONE;

    always_comb begin
        head_instr      = '0;
        head_instr.pc   = head_pc;
        head_instr.is32 = head_is32;
        if (has_one) begin
            head_instr.data[HALF_W-1:0] = head_word;
        end
        if (head_is32 && has_two) begin
            head_instr.data[INSTR_W-1:HALF_W] = next_word;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            head_pc  <= RESET_PC;
            inflight <= 1'b0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= bus.redirect_pc;
            head_pc  <= bus.redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + pc_t'(1);
            end
            head_pc <= head_pc + pc_t'(pop);
        end
    end

    // The empty queue would otherwise request a read while reset is held.
    assign bus.mem_rd_en   = issue && reset;
    assign bus.mem_rd_addr = fetch_pc;

    assign bus.instr_valid = head_valid;
    assign bus.instr_data  = head_instr.data;
    assign bus.instr_pc    = head_instr.pc;
    assign bus.instr_is32  = head_instr.is32;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Randomised scoreboard bench for instr_prefetch_queue: expected instruction
// streams are walked from memory contents at every reset/redirect.
module tb_instr_prefetch_queue;
    import instr_prefetch_queue_pkg::*;

    localparam int  DEPTH      = 4;
    localparam pc_t RST_PC     = 20'h00000;
    localparam int  STREAM_LEN = 64;

    logic   clock = 1'b0;
    logic   reset = 1'b1;
    int     errors = 0;
    int     checks = 0;
    int     accepts = 0;
    int     reads;
    int     n_cyc;
    bit     found;
    pc_t    target;
    instr_t rec;
    instr_t now_head;
    instr_t mon_got;
    instr_t held;
    logic   hold_prev = 1'b0;

    instr_t exp_q[$];
    half_t  mem_aa [pc_t];

    instr_prefetch_queue_if bus();

    instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic half_t mem_word(input pc_t a);
        logic [31:0] h;
        if (mem_aa.exists(a)) return mem_aa[a];
        h = {12'h0, a} * 32'h9E3779B1;
        return h[31:16] ^ h[15:0];
    endfunction

    // Instructions are laid out back to back from the start PC: bit 15 of the
    // first halfword marks a 32-bit instruction that consumes two halfwords.
    task automatic load_stream(input pc_t start);
        pc_t    pc;
        half_t  first;
        instr_t e;
        pc = start;
        exp_q.delete();
        for (int i = 0; i < STREAM_LEN; i++) begin
            first  = mem_word(pc);
            e.pc   = pc;
            e.is32 = first[15];
            e.data = e.is32 ? {mem_word(pc + 20'd1), first} : {16'h0000, first};
            exp_q.push_back(e);
            pc = pc + (e.is32 ? 20'd2 : 20'd1);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Memory: data for a strobed address appears the next cycle, noise otherwise.
    always @(posedge clock) begin
        bus.mem_rd_data <= bus.mem_rd_en ? mem_word(bus.mem_rd_addr) : half_t'($urandom);
    end

    always @(negedge clock) begin
        mon_got = '{data: bus.instr_data, pc: bus.instr_pc, is32: bus.instr_is32};
        if (reset && hold_prev && !bus.redirect_valid) begin
            chk("hold_valid", 64'(bus.instr_valid), 64'd1);
            chk("hold_head", 64'(mon_got), 64'(held));
        end
        if (reset && bus.instr_valid && bus.instr_ready) begin
            accepts++;
            chk("stream_avail", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("stream", 64'(mon_got), 64'(exp_q.pop_front()));
        end
        hold_prev = reset && bus.instr_valid && !bus.instr_ready;
        held      = mon_got;
    end

    task automatic apply_reset(input bit check_vals);
        reset = 1'b0;
        bus.redirect_valid = 1'b0;
        #1;
        if (check_vals) begin
            chk("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
            chk("rst_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
            chk("rst_instr_data", 64'(bus.instr_data), 64'd0);
            chk("rst_instr_is32", 64'(bus.instr_is32), 64'd0);
            chk("rst_instr_pc", 64'(bus.instr_pc), 64'(RST_PC));
            chk("rst_mem_rd_addr", 64'(bus.mem_rd_addr), 64'(RST_PC));
        end
        cyc();
        cyc();
        load_stream(RST_PC);
        reset = 1'b1;
    endtask

    task automatic redirect_to(input pc_t pc);
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        load_stream(pc);
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b1;

        // Three 16-bit instructions straight out of reset.
        mem_aa[20'h0] = 16'h0001;
        mem_aa[20'h1] = 16'h0002;
        mem_aa[20'h2] = 16'h0003;
        #2;
        apply_reset(1'b1);
        #1;
        chk("c0_rd_en", 64'(bus.mem_rd_en), 64'd1);
        chk("c0_rd_addr", 64'(bus.mem_rd_addr), 64'h0);
        cyc(); #1;
        chk("c1_valid", 64'(bus.instr_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("seq_valid", 64'(bus.instr_valid), 64'd1);
            chk("seq_data", 64'(bus.instr_data), 64'(i + 1));
            chk("seq_pc", 64'(bus.instr_pc), 64'(i));
            chk("seq_is32", 64'(bus.instr_is32), 64'd0);
        end

        // 32-bit assembly from two halfwords.
        mem_aa[20'h0] = 16'h8123;
        mem_aa[20'h1] = 16'h4567;
        mem_aa[20'h2] = 16'h0005;
        apply_reset(1'b0);
        cyc(); cyc(); #1;
        chk("half32_wait", 64'(bus.instr_valid), 64'd0);
        chk("half32_is32", 64'(bus.instr_is32), 64'd1);
        cyc(); #1;
        chk("i32_valid", 64'(bus.instr_valid), 64'd1);
        chk("i32_data", 64'(bus.instr_data), 64'h45678123);
        chk("i32_is32", 64'(bus.instr_is32), 64'd1);
        chk("i32_pc", 64'(bus.instr_pc), 64'h0);
        cyc(); #1;
        chk("after32_valid", 64'(bus.instr_valid), 64'd1);
        chk("after32_pc", 64'(bus.instr_pc), 64'h2);

        // Backpressure: the queue fills to DEPTH, then reads stop.
        bus.instr_ready = 1'b0;
        redirect_to(20'h00200);
        cyc();
        bus.redirect_valid = 1'b0;
        reads = 0;
        for (int i = 0; i < 12; i++) begin
            if (i != 0) cyc();
            #1;
            if (bus.mem_rd_en) reads++;
            if (i == 5) rec = '{data: bus.instr_data, pc: bus.instr_pc, is32: bus.instr_is32};
        end
        now_head = '{data: bus.instr_data, pc: bus.instr_pc, is32: bus.instr_is32};
        chk("bp_reads", 64'(reads), 64'(DEPTH));
        chk("bp_rd_en_low", 64'(bus.mem_rd_en), 64'd0);
        chk("bp_valid", 64'(bus.instr_valid), 64'd1);
        chk("bp_head_held", 64'(now_head), 64'(rec));
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) cyc();

        // Redirect while a read is in flight, with the decoder ready.
        mem_aa[20'h00100] = 16'h1234;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc(); #1;
            if (bus.mem_rd_en) found = 1'b1;
        end
        chk("inflight_seen", 64'(found), 64'd1);
        redirect_to(20'h00100);
        #1;
        chk("redir_valid_low", 64'(bus.instr_valid), 64'd0);
        chk("redir_no_issue", 64'(bus.mem_rd_en), 64'd0);
        cyc();
        bus.redirect_valid = 1'b0;
        #1;
        chk("redir_k1_rd_en", 64'(bus.mem_rd_en), 64'd1);
        chk("redir_k1_addr", 64'(bus.mem_rd_addr), 64'h00100);
        cyc(); #1;
        chk("redir_k2_valid", 64'(bus.instr_valid), 64'd0);
        cyc(); #1;
        chk("redir_k3_valid", 64'(bus.instr_valid), 64'd1);
        chk("redir_k3_pc", 64'(bus.instr_pc), 64'h00100);
        chk("redir_k3_data", 64'(bus.instr_data), 64'h1234);

        // 32-bit instruction whose second half lands a cycle after the first.
        mem_aa[20'h00180] = 16'h9ABC;
        mem_aa[20'h00181] = 16'hDEF0;
        redirect_to(20'h00180);
        cyc();
        bus.redirect_valid = 1'b0;
        cyc(); cyc(); #1;
        chk("split_k3_valid", 64'(bus.instr_valid), 64'd0);
        cyc(); #1;
        chk("split_k4_valid", 64'(bus.instr_valid), 64'd1);
        chk("split_k4_data", 64'(bus.instr_data), 64'hDEF09ABC);
        chk("split_k4_pc", 64'(bus.instr_pc), 64'h00180);

        // Back-to-back redirects: the second target is the one fetched.
        redirect_to(20'h00400);
        cyc();
        bus.redirect_pc = 20'h00100;
        load_stream(20'h00100);
        cyc();
        bus.redirect_valid = 1'b0;
        cyc(); cyc(); #1;
        chk("b2b_valid", 64'(bus.instr_valid), 64'd1);
        chk("b2b_pc", 64'(bus.instr_pc), 64'h00100);

        // Asynchronous reset in the middle of streaming.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc(); #1;
            if (bus.instr_valid) found = 1'b1;
        end
        chk("pre_reset_valid", 64'(found), 64'd1);
        apply_reset(1'b1);
        #1;
        chk("restart_rd_en", 64'(bus.mem_rd_en), 64'd1);
        chk("restart_addr", 64'(bus.mem_rd_addr), 64'(RST_PC));

        // Randomised segments: random targets (including the address wrap),
        // occasional double redirects and random decoder readiness.
        for (int seg = 0; seg < 25; seg++) begin
            case ($urandom_range(0, 3))
                0:       target = 20'hFFFFC + pc_t'($urandom_range(0, 3));
                1:       target = pc_t'($urandom_range(0, 64));
                default: target = pc_t'($urandom);
            endcase
            redirect_to(target);
            bus.instr_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                cyc();
                target = pc_t'($urandom);
                bus.redirect_pc = target;
                load_stream(target);
            end
            cyc();
            bus.redirect_valid = 1'b0;
            n_cyc = $urandom_range(30, 50);
            for (int i = 0; i < n_cyc; i++) begin
                cyc();
                bus.instr_ready = ($urandom_range(0, 3) != 0);
            end
        end
        cyc();
        chk("accept_volume", 64'(accepts >= 100), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Sits between instruction memory (20-bit word address, 16-bit data) and the 32-bit decoder.
- Streams 16-bit halfwords into a small queue and assembles complete 16- or 32-bit AAP instructions for the decoder.
- Each instruction is presented with its PC.
- Discards all buffered and in-flight words on a redirect (branch or flush) from execute.

Parameters:
- DEPTH, 4, queue capacity in 16-bit halfwords (power of two, minimum 2).
- RESET_PC, 20'h00000, fetch word address after reset.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (reset==0 asserts)
- mem_rd_en  output  1  instruction memory read strobe
- mem_rd_addr  output  20  halfword address of the read
- mem_rd_data  input  16  read data, valid the cycle after mem_rd_en
- redirect_valid  input  1  redirect request from execute
- redirect_pc  input  20  new fetch halfword address
- instr_valid  output  1  complete instruction at queue head
- instr_ready  input  1  decoder accepts the instruction
- instr_data  output  32  [15:0] first halfword, [31:16] second halfword (zero for 16-bit)
- instr_pc  output  20  halfword address of the first halfword
- instr_is32  output  1  head instruction is 32-bit (first halfword bit 15 set)

Behaviour:
- Reset (async, reset==0):
  - fetch_pc = RESET_PC, head_pc = RESET_PC.
  - Queue count = 0, inflight = 0.
  - mem_rd_en = 0, instr_valid = 0, instr_data = 0, instr_is32 = 0.
  - instr_pc = RESET_PC, mem_rd_addr = RESET_PC.
- Issue:
  - mem_rd_en = 1 when (count + inflight) < DEPTH and redirect_valid = 0; mem_rd_addr = fetch_pc.
  - On issue: fetch_pc += 1, wrapping modulo 2^20; inflight set for the next cycle.
  - Back-to-back issue every cycle is allowed.
  - Pops in the same cycle are not credited, so the issue decision is conservative.
- Fill: when inflight = 1, mem_rd_data is written at the queue tail at the end of that cycle.
- Capacity: the queue never overflows (guaranteed by the issue rule); an overflow is an assertion failure.
- Head decode (combinational from queue contents):
  - is32 = head[15].
  - instr_valid = !redirect_valid && ((count >= 1 && !is32) || (count >= 2 && is32)).
- Pop on instr_valid && instr_ready:
  - Remove 1 halfword if 16-bit, 2 if 32-bit.
  - head_pc += 1 or 2 (wrapping).
  - Pop and fill in the same cycle are both applied; count updates by fill minus pop.
- 32-bit instruction with only its first halfword present: instr_valid = 0; wait for the second halfword.
- Redirect (sampled at edge k):
  - Queue emptied, inflight cleared; any read data arriving in cycle k+1 is discarded.
  - fetch_pc = head_pc = redirect_pc.
  - No issue during the redirect cycle.
  - First read issued in cycle k+1; data present in k+2; earliest instr_valid in k+3.
- Redirect coincident with instr_ready: no pop; redirect wins.
- Back-to-back redirects: the last one wins.
- Reset mid-stream: all state returns to reset values immediately, and any in-flight response is ignored.
- Outputs are stable while instr_valid = 1 and instr_ready = 0.

Decomposition:
- Shared package contents:
  - INSTR_ADDR_W = 20, HALF_W = 16.
  - IS32_BIT = 15.
  - Struct/typedef for {data[31:0], pc[19:0], is32}.
- One sub-module, prefetch_fifo:
  - Circular halfword buffer with head/tail pointers and count.
  - Ports: push (1), pop (0/1/2), clear; exposes head and head+1 words.
- Top level holds fetch_pc, head_pc, inflight, the issue rule and the assembly logic.

Test Plan:
- Reset release with memory holding 16-bit words 0x0001, 0x0002, 0x0003 at 0..2, instr_ready=1:
  - Read of address 0 in the first cycle after release.
  - Instructions 0x00000001 @pc 0, 0x00000002 @pc 1, 0x00000003 @pc 2 on consecutive cycles, is32=0.
- 32-bit assembly with words 0x8123, 0x4567 at 0..1:
  - Single instruction, instr_data = 0x45678123, is32 = 1, pc 0; next instruction pc = 2.
- Backpressure with instr_ready=0 for 10 cycles:
  - Count saturates at DEPTH=4 and mem_rd_en drops to 0.
  - Head outputs are held constant.
  - Raising ready resumes in order with no lost or duplicated words.
- Redirect to 0x00100 while a read is in flight:
  - Stale response discarded.
  - mem_rd_addr = 0x00100 in cycle k+1; first instr_valid in k+3 with instr_pc = 0x00100.
- Split 32-bit instruction with a one-cycle memory stall between halfwords:
  - instr_valid stays 0 until the second half arrives, then presents the full word.
- Redirect with instr_ready=1 in the same cycle, and async reset asserted mid-fetch:
  - Redirect case: no pop counted.
  - Reset case: instr_valid falls immediately without waiting for a clock edge; restart from RESET_PC.
